// File: rtl/shift_register_pkg.sv
// Shared constants and types for the 4-bit PISO shift register.
package shift_register_pkg;

  localparam int SR_WIDTH   = 4;
  localparam int SR_PHASE_W = 2;

  typedef logic [SR_WIDTH-1:0]   sr_word_t;
  typedef logic [SR_PHASE_W-1:0] sr_phase_t;

  localparam sr_phase_t SR_PHASE_LOAD = '0;

endpackage

// File: rtl/shift_frame_counter.sv
// Free-running 2-bit frame phase counter.
// o_load marks the frame's first cycle.
module shift_frame_counter
  import shift_register_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  output sr_phase_t o_phase,
  output logic      o_load
);

  sr_phase_t r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= SR_PHASE_LOAD;
    end else begin
      r_phase <= r_phase + sr_phase_t'(1);
    end
  end

  assign o_phase = r_phase;
  assign o_load  = (r_phase == SR_PHASE_LOAD);

endmodule

// File: rtl/shift_register_4_bit.sv
// 4-bit parallel-in serial-out register, one word per 4-cycle frame.
// Define SHIFT_REGISTER_LSB_FIRST_EN for LSB-first output order.
module shift_register_4_bit
  import shift_register_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  sr_word_t in,
  output logic     out
);

  sr_phase_t w_phase;
  logic      w_load;
  logic      w_shift;
  sr_word_t  r_shreg;

  shift_frame_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_phase (w_phase),
    .o_load  (w_load)
  );

  assign w_shift = (w_phase != SR_PHASE_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= in;
    end else if (w_shift) begin
`ifdef SHIFT_REGISTER_LSB_FIRST_EN
      r_shreg <= {1'b0, r_shreg[SR_WIDTH-1:1]};
`else
      r_shreg <= {r_shreg[SR_WIDTH-2:0], 1'b0};
`endif
    end
  end

`ifdef SHIFT_REGISTER_LSB_FIRST_EN
  assign out = r_shreg[0];
`else
  assign out = r_shreg[SR_WIDTH-1];
`endif

endmodule

// File: tb/tb_shift_register_4_bit.sv
// Scoreboard bench for shift_register_4_bit.
module tb_shift_register_4_bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_w = 4'h0;
  logic       out_w;

  bit exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  shift_register_4_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_w),
    .out   (out_w)
  );

  always #5 clk = ~clk;

  function automatic bit ref_bit(input int w, input int i);
`ifdef SHIFT_REGISTER_LSB_FIRST_EN
    return bit'((w >> i) & 1);
`else
    return bit'((w >> (3 - i)) & 1);
`endif
  endfunction

  always @(negedge clk) begin
    bit e;
    if (!rst_n) begin
      vectors++;
      if (out_w !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out: got %b want 0", out_w);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (out_w !== e) begin
        miscompares++;
        $display("FAIL serial_bit @%0t: got %b want %b",
                 $time, out_w, e);
      end
    end
  end

  task automatic push_word(input int w);
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_bit(w, i));
  endtask

  task automatic frame(input int w);
    in_w = 4'(w);
    push_word(w);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic mid_change();
    in_w = 4'b1110;
    push_word(4'b1110);
    @(negedge clk);
    #1;
    in_w = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    frame(0);
  endtask

  task automatic mid_reset();
    in_w = 4'b1111;
    exp_q.push_back(ref_bit(15, 0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_w !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want 0", out_w);
    end
    in_w = 4'b1001;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    frame(4'b1001);
  endtask

  initial begin
    in_w  = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    frame(4'hF);
    frame(4'hA);
    frame(4'h8);
    frame(4'h1);
    mid_change();
    mid_reset();
    for (int v = 0; v < 16; v++) frame(v);
    for (int k = 0; k < 24; k++) frame(int'($urandom_range(0, 15)));
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
